// File: rtl/mesh_store_pkg.sv
// mesh_store_pkg
//   Shared constants for the double-buffered mesh store: default index
//   widths, vertex field layout, stored-word width, and the state encodings
//   of the warp-side and CPU-side bus FSMs.
package mesh_store_pkg;

   localparam int X_BITS_DEF = 7;   // word adr[6:0] = X, fixed by fetcher layout
   localparam int Y_BITS_DEF = 5;

   // A vertex word carries two 11-bit fields: x at [10:0], y at [26:16].
   localparam int          FIELD_W    = 11;
   localparam logic [10:0] FIELD_MASK = 11'h7FF;
   localparam int          STORE_W    = 2 * FIELD_W;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_READ = 2'd1,
      R_ACK  = 2'd2
   } rstate_e;

   typedef enum logic [1:0] {
      C_IDLE = 2'd0,
      C_READ = 2'd1,
      C_ACK  = 2'd2
   } cstate_e;

   // Re-expand a stored 22-bit entry into the 32-bit bus layout; every bit
   // outside the two fields reads as zero.
   function automatic logic [31:0] vtx_unpack(input logic [STORE_W-1:0] s);
      return {5'b0, s[STORE_W-1:FIELD_W] & FIELD_MASK,
              5'b0, s[FIELD_W-1:0] & FIELD_MASK};
   endfunction

endpackage

// File: rtl/mesh_bank.sv
// mesh_bank
//   One bank of mesh storage: single write port, single read port,
//   synchronous read with one cycle of latency. The read port samples its
//   address every cycle; the owner decides when the result is meaningful.
// Ports
//   clk      clock
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data (packed vertex fields)
//   raddr_i  read word index
//   rdata_o  read data, registered
module mesh_bank
   import mesh_store_pkg::*;
#(
   parameter int AW = X_BITS_DEF + Y_BITS_DEF,
   parameter int DW = STORE_W
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mesh_store.sv
// mesh_store
//   Double-buffered mesh memory. The warp side reads the front bank through
//   a read-only WISHBONE slave; the CPU reads/writes the back bank through a
//   second slave. A requested swap waits until warp is idle and both bus FSMs
//   are in their idle state, then flips the bank roles in a single edge.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   rwb_adr_i/stb_i/ack_o/dat_o  warp-side read bus (3 cycles per word)
//   cwb_adr_i/dat_i/we_i/stb_i/ack_o/dat_o  CPU-side bus on the back bank
//   swap_req      one-cycle swap request pulse
//   warp_idle     fetcher finished; swap may proceed
//   swap_pending  swap requested but not yet performed
//   front_bank    bank currently served to the warp side
module mesh_store
   import mesh_store_pkg::*;
#(
   parameter int X_BITS = X_BITS_DEF,
   parameter int Y_BITS = Y_BITS_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] rwb_adr_i,
   input  logic        rwb_stb_i,
   output logic        rwb_ack_o,
   output logic [31:0] rwb_dat_o,
   input  logic [31:0] cwb_adr_i,
   input  logic [31:0] cwb_dat_i,
   input  logic        cwb_we_i,
   input  logic        cwb_stb_i,
   output logic        cwb_ack_o,
   output logic [31:0] cwb_dat_o,
   input  logic        swap_req,
   input  logic        warp_idle,
   output logic        swap_pending,
   output logic        front_bank
);

   localparam int AW = X_BITS + Y_BITS;

   rstate_e     rstate_q;
   cstate_e     cstate_q;
   logic        rwb_ack_q, cwb_ack_q;
   logic [31:0] rwb_dat_q, cwb_dat_q;
   logic        swap_pending_q, swap_pending_d;
   logic        front_bank_q, front_bank_d;

   // Y sits directly above X in the word address, so one slice gives {Y,X};
   // higher address bits alias and the byte offset is dropped.
   logic [AW-1:0]      r_idx, c_idx;
   logic [STORE_W-1:0] c_wdata;
   assign r_idx   = rwb_adr_i[2 +: AW];
   assign c_idx   = cwb_adr_i[2 +: AW];
   assign c_wdata = {cwb_dat_i[26:16], cwb_dat_i[10:0]};

   logic unused_bits;
   assign unused_bits = ^{rwb_adr_i[31:2+AW], rwb_adr_i[1:0],
                          cwb_adr_i[31:2+AW], cwb_adr_i[1:0],
                          cwb_dat_i[31:27], cwb_dat_i[15:11]};

   // Swap only when neither port is mid-transaction, so no access ever
   // straddles a role change.
   logic swap_fire;
   assign swap_fire = swap_pending_q && warp_idle &&
                      (rstate_q == R_IDLE) && (cstate_q == C_IDLE);

   // A strobe seen on the swap edge is deferred one cycle so it starts
   // against the new bank roles.
   logic c_wr_commit;
   assign c_wr_commit = (cstate_q == C_IDLE) && cwb_stb_i && cwb_we_i && !swap_fire;

   logic [1:0]                we;
   logic [1:0][AW-1:0]        raddr;
   logic [1:0][STORE_W-1:0]   rdata;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      // Front bank reads the warp address; back bank serves the CPU.
      assign we[b]    = c_wr_commit && (front_bank_q != 1'(b));
      assign raddr[b] = (front_bank_q == 1'(b)) ? r_idx : c_idx;

      mesh_bank #(.AW(AW), .DW(STORE_W)) u_bank (
         .clk     (clk),
         .we_i    (we[b]),
         .waddr_i (c_idx),
         .wdata_i (c_wdata),
         .raddr_i (raddr[b]),
         .rdata_o (rdata[b])
      );
   end

   logic [STORE_W-1:0] front_rdata, back_rdata;
   assign front_rdata = rdata[front_bank_q];
   assign back_rdata  = rdata[~front_bank_q];

   // Warp FSM. The RAM samples the bus address on the edge leaving R_IDLE;
   // R_ACK never samples stb, so a held strobe cannot produce a double ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstate_q  <= R_IDLE;
         rwb_ack_q <= 1'b0;
         rwb_dat_q <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: if (rwb_stb_i && !swap_fire) rstate_q <= R_READ;
            R_READ: begin
               rwb_dat_q <= vtx_unpack(front_rdata);
               rwb_ack_q <= 1'b1;
               rstate_q  <= R_ACK;
            end
            R_ACK: begin
               rwb_ack_q <= 1'b0;
               rstate_q  <= R_IDLE;
            end
            default: begin
               rwb_ack_q <= 1'b0;
               rstate_q  <= R_IDLE;
            end
         endcase
      end
   end

   // CPU FSM. Writes commit on the edge leaving C_IDLE and ack next cycle;
   // reads take the extra C_READ cycle for the RAM latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cstate_q  <= C_IDLE;
         cwb_ack_q <= 1'b0;
         cwb_dat_q <= '0;
      end else begin
         case (cstate_q)
            C_IDLE: begin
               if (c_wr_commit) begin
                  cwb_ack_q <= 1'b1;
                  cstate_q  <= C_ACK;
               end else if (cwb_stb_i && !swap_fire) begin
                  cstate_q  <= C_READ;
               end
            end
            C_READ: begin
               cwb_dat_q <= vtx_unpack(back_rdata);
               cwb_ack_q <= 1'b1;
               cstate_q  <= C_ACK;
            end
            C_ACK: begin
               cwb_ack_q <= 1'b0;
               cstate_q  <= C_IDLE;
            end
            default: begin
               cwb_ack_q <= 1'b0;
               cstate_q  <= C_IDLE;
            end
         endcase
      end
   end

   // A request arriving on the executing swap edge is absorbed by that swap.
   always_comb begin
      swap_pending_d = swap_pending_q | swap_req;
      front_bank_d   = front_bank_q;
      if (swap_fire) begin
         swap_pending_d = 1'b0;
         front_bank_d   = ~front_bank_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         swap_pending_q <= 1'b0;
         front_bank_q   <= 1'b0;
      end else begin
         swap_pending_q <= swap_pending_d;
         front_bank_q   <= front_bank_d;
      end
   end

   assign rwb_ack_o    = rwb_ack_q;
   assign rwb_dat_o    = rwb_dat_q;
   assign cwb_ack_o    = cwb_ack_q;
   assign cwb_dat_o    = cwb_dat_q;
   assign swap_pending = swap_pending_q;
   assign front_bank   = front_bank_q;

endmodule

// File: tb/tb_mesh_store.sv
// Directed bench for mesh_store: bus transactions on both ports, bank swap
// handshake, held-strobe throughput, field masking and mid-access reset.
module tb_mesh_store;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] rwb_adr_i = '0;
   logic        rwb_stb_i = 1'b0;
   logic        rwb_ack_o;
   logic [31:0] rwb_dat_o;
   logic [31:0] cwb_adr_i = '0;
   logic [31:0] cwb_dat_i = '0;
   logic        cwb_we_i = 1'b0;
   logic        cwb_stb_i = 1'b0;
   logic        cwb_ack_o;
   logic [31:0] cwb_dat_o;
   logic        swap_req = 1'b0;
   logic        warp_idle = 1'b1;
   logic        swap_pending;
   logic        front_bank;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mesh_store dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rwb_adr_i    (rwb_adr_i),
      .rwb_stb_i    (rwb_stb_i),
      .rwb_ack_o    (rwb_ack_o),
      .rwb_dat_o    (rwb_dat_o),
      .cwb_adr_i    (cwb_adr_i),
      .cwb_dat_i    (cwb_dat_i),
      .cwb_we_i     (cwb_we_i),
      .cwb_stb_i    (cwb_stb_i),
      .cwb_ack_o    (cwb_ack_o),
      .cwb_dat_o    (cwb_dat_o),
      .swap_req     (swap_req),
      .warp_idle    (warp_idle),
      .swap_pending (swap_pending),
      .front_bank   (front_bank)
   );

   // ---- bus drivers (no checking; lat = -1 on timeout) ----
   task automatic cpu_write(input logic [31:0] adr, input logic [31:0] dat, output int lat);
      lat = -1;
      @(posedge clk); #1;
      cwb_adr_i = adr; cwb_dat_i = dat; cwb_we_i = 1'b1; cwb_stb_i = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (cwb_ack_o) begin lat = n; break; end
      end
      cwb_stb_i = 1'b0; cwb_we_i = 1'b0;
   endtask

   task automatic cpu_read(input logic [31:0] adr, output logic [31:0] dat, output int lat);
      lat = -1; dat = 'x;
      @(posedge clk); #1;
      cwb_adr_i = adr; cwb_we_i = 1'b0; cwb_stb_i = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (cwb_ack_o) begin lat = n; dat = cwb_dat_o; break; end
      end
      cwb_stb_i = 1'b0;
   endtask

   task automatic warp_read(input logic [31:0] adr, output logic [31:0] dat, output int lat);
      lat = -1; dat = 'x;
      @(posedge clk); #1;
      rwb_adr_i = adr; rwb_stb_i = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (rwb_ack_o) begin lat = n; dat = rwb_dat_o; break; end
      end
      rwb_stb_i = 1'b0;
   endtask

   // Pending is set on the first edge; the swap can execute on the next.
   task automatic pulse_swap();
      @(posedge clk); #1 swap_req = 1'b1;
      @(posedge clk); #1 swap_req = 1'b0;
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (rwb_ack_o !== 1'b0 || cwb_ack_o !== 1'b0) begin
         tests_failed++; $display("FAIL reset_acks: got %b/%b expected 0/0", rwb_ack_o, cwb_ack_o);
      end
      tests_run++;
      if (rwb_dat_o !== 32'h0 || cwb_dat_o !== 32'h0) begin
         tests_failed++; $display("FAIL reset_dat: got %h/%h expected 0/0", rwb_dat_o, cwb_dat_o);
      end
      tests_run++;
      if (swap_pending !== 1'b0 || front_bank !== 1'b0) begin
         tests_failed++; $display("FAIL reset_swap: got pend=%b front=%b expected 0/0", swap_pending, front_bank);
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] d; int l;
      cpu_write(32'h0000_040C, 32'h0123_0456, l);
      tests_run++;
      if (l !== 2) begin tests_failed++; $display("FAIL basic_wr_lat: got %0d expected 2", l); end
      warp_idle = 1'b1;
      pulse_swap();
      @(posedge clk); @(negedge clk);
      tests_run++;
      if (front_bank !== 1'b1 || swap_pending !== 1'b0) begin
         tests_failed++; $display("FAIL basic_swap: got front=%b pend=%b expected 1/0", front_bank, swap_pending);
      end
      warp_read(32'h0000_040C, d, l);
      tests_run++;
      if (l !== 3) begin tests_failed++; $display("FAIL basic_rd_lat: got %0d expected 3", l); end
      tests_run++;
      if (d !== 32'h0123_0456) begin tests_failed++; $display("FAIL basic_rd_dat: got %h expected 01230456", d); end
   endtask

   task automatic test_swap_pending();
      warp_idle = 1'b0;
      pulse_swap();
      @(negedge clk);
      tests_run++;
      if (swap_pending !== 1'b1 || front_bank !== 1'b1) begin
         tests_failed++; $display("FAIL pend_set: got pend=%b front=%b expected 1/1", swap_pending, front_bank);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (swap_pending !== 1'b1 || front_bank !== 1'b1) begin
         tests_failed++; $display("FAIL pend_hold: got pend=%b front=%b expected 1/1", swap_pending, front_bank);
      end
      @(posedge clk); #1 warp_idle = 1'b1;
      @(negedge clk);
      tests_run++;
      if (front_bank !== 1'b1) begin tests_failed++; $display("FAIL pend_early: got front=%b expected 1", front_bank); end
      @(posedge clk); @(negedge clk);
      tests_run++;
      if (swap_pending !== 1'b0 || front_bank !== 1'b0) begin
         tests_failed++; $display("FAIL pend_fire: got pend=%b front=%b expected 0/0", swap_pending, front_bank);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] adr [4];
      logic [31:0] dat [4];
      int l, nack, last;
      for (int i = 0; i < 4; i++) begin
         adr[i] = 32'h0000_0200 | (i << 2);
         dat[i] = 32'h000A_0100 + i * 32'h0001_0001;
         cpu_write(adr[i], dat[i], l);
      end
      pulse_swap();
      @(posedge clk); @(negedge clk);
      tests_run++;
      if (front_bank !== 1'b1) begin tests_failed++; $display("FAIL b2b_swap: got front=%b expected 1", front_bank); end
      nack = 0; last = 0;
      @(posedge clk); #1;
      rwb_adr_i = adr[0]; rwb_stb_i = 1'b1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         if (rwb_ack_o) begin
            if (nack < 4) begin
               tests_run++;
               if (rwb_dat_o !== dat[nack]) begin
                  tests_failed++; $display("FAIL b2b_dat%0d: got %h expected %h", nack, rwb_dat_o, dat[nack]);
               end
               tests_run++;
               if (cyc - last !== 3) begin
                  tests_failed++; $display("FAIL b2b_gap%0d: got %0d expected 3", nack, cyc - last);
               end
            end
            last = cyc;
            nack++;
            if (nack < 4) rwb_adr_i = adr[nack];
            else rwb_stb_i = 1'b0;
         end
      end
      rwb_stb_i = 1'b0;
      tests_run++;
      if (nack !== 4) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 4", nack); end
   endtask

   task automatic test_mask();
      logic [31:0] d; int l;
      cpu_write(32'h0000_0614, 32'hFFFF_FFFF, l);
      cpu_read(32'h0000_0614, d, l);
      tests_run++;
      if (l !== 3) begin tests_failed++; $display("FAIL mask_cpu_lat: got %0d expected 3", l); end
      tests_run++;
      if (d !== 32'h07FF_07FF) begin tests_failed++; $display("FAIL mask_cpu_dat: got %h expected 07ff07ff", d); end
      pulse_swap();
      @(posedge clk); @(negedge clk);
      tests_run++;
      if (front_bank !== 1'b0) begin tests_failed++; $display("FAIL mask_swap: got front=%b expected 0", front_bank); end
      warp_read(32'h0000_0614, d, l);
      tests_run++;
      if (d !== 32'h07FF_07FF) begin tests_failed++; $display("FAIL mask_warp_dat: got %h expected 07ff07ff", d); end
      // upper address bits and byte offset are ignored
      warp_read(32'hABCD_C617, d, l);
      tests_run++;
      if (d !== 32'h07FF_07FF) begin tests_failed++; $display("FAIL alias_dat: got %h expected 07ff07ff", d); end
   endtask

   task automatic test_concurrency();
      logic [31:0] d; int l1, l2;
      cpu_write(32'h0, 32'h0011_0022, l1);
      pulse_swap();
      @(posedge clk); @(negedge clk);
      fork
         cpu_write(32'h0, 32'h0033_0044, l1);
         warp_read(32'h0, d, l2);
      join
      tests_run++;
      if (d !== 32'h0011_0022) begin tests_failed++; $display("FAIL conc_old: got %h expected 00110022", d); end
      tests_run++;
      if (l1 !== 2 || l2 !== 3) begin tests_failed++; $display("FAIL conc_lat: got %0d/%0d expected 2/3", l1, l2); end
      warp_read(32'h0, d, l2);
      tests_run++;
      if (d !== 32'h0011_0022) begin tests_failed++; $display("FAIL conc_still: got %h expected 00110022", d); end
      pulse_swap();
      @(posedge clk); @(negedge clk);
      warp_read(32'h0, d, l2);
      tests_run++;
      if (d !== 32'h0033_0044) begin tests_failed++; $display("FAIL conc_new: got %h expected 00330044", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; int l, nack;
      pulse_swap();                       // front -> 1
      @(posedge clk);
      warp_idle = 1'b0;
      pulse_swap();                       // leaves a swap pending
      @(posedge clk); #1;
      rwb_adr_i = 32'h0000_0614; rwb_stb_i = 1'b1;
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      tests_run++;
      if (rwb_ack_o !== 1'b0 || rwb_dat_o !== 32'h0) begin
         tests_failed++; $display("FAIL rstmid_out: got ack=%b dat=%h expected 0/0", rwb_ack_o, rwb_dat_o);
      end
      tests_run++;
      if (front_bank !== 1'b0 || swap_pending !== 1'b0) begin
         tests_failed++; $display("FAIL rstmid_swap: got front=%b pend=%b expected 0/0", front_bank, swap_pending);
      end
      @(posedge clk); #1;
      rwb_stb_i = 1'b0; rst_n = 1'b1; warp_idle = 1'b1;
      nack = 0;
      repeat (5) begin @(negedge clk); if (rwb_ack_o) nack++; end
      tests_run++;
      if (nack !== 0) begin tests_failed++; $display("FAIL rstmid_noack: got %0d acks expected 0", nack); end
      warp_read(32'h0000_0614, d, l);
      tests_run++;
      if (l !== 3 || d !== 32'h07FF_07FF) begin
         tests_failed++; $display("FAIL rstmid_after: got lat=%0d dat=%h expected 3/07ff07ff", l, d);
      end
      warp_read(32'h0, d, l);
      tests_run++;
      if (d !== 32'h0033_0044) begin tests_failed++; $display("FAIL rstmid_bank0: got %h expected 00330044", d); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_swap_pending();
      test_back_to_back();
      test_mask();
      test_concurrency();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
